d7s_scan_bcd: RTL and testbench

Parametrised multiplexed seven-segment display controller. It accepts a binary value through a load/ready handshake and converts it to BCD with a sequential double-dabble engine. It scans `DIGITS` common-driver digits with a programmable dwell time, and supports leading-zero blanking, per-digit decimal points, overflow indication and selectable output polarity. It is the generalised successor of the fixed three-digit display driver and sits directly behind the top-level `uo_out` / `uio_out` pin assignments.

---
 rtl/d7s_scan_bcd_if.sv | 11 +
 rtl/d7s_scan_bcd.sv | 170 +++++++++++++++++
 tb/tb_d7s_scan_bcd.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/d7s_scan_bcd_if.sv
// Load/ready handshake carrying the binary value into the display controller.
interface d7s_scan_bcd_if #(
    parameter int unsigned BIN_W = 10
);
    logic [BIN_W-1:0] bin_in;
    logic             load;
    logic             ready;

    modport master (output bin_in, output load, input ready);
    modport slave  (input bin_in, input load, output ready);
endinterface

// File: rtl/d7s_scan_bcd.sv
// Multiplexed seven-segment controller: sequential double-dabble conversion,
// digit scanning, leading-zero blanking, overflow dashes and output polarity.
module d7s_scan_bcd #(
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned BIN_W       = 10,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter bit          SEG_ACT_LOW = 1'b0,
    parameter bit          DIG_ACT_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    d7s_scan_bcd_if.slave     bus,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] dig_en,
    output logic              ovf
);
    localparam int unsigned NIB    = (BIN_W + 2) / 3;
    localparam int unsigned BCD_W  = 4 * NIB;
    localparam int unsigned DISP_N = (NIB < DIGITS) ? NIB : DIGITS;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam int unsigned PS_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS*4-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d, seg_raw;
    logic                dp_q, dp_d, dp_raw;
    logic [DIGITS-1:0]   dig_q, dig_d, dig_raw;
    logic [3:0]          cur_dig;
    logic                upper_zero;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Conversion FSM
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < NIB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    bin_d   = bus.bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = StCommit;
            end
            StCommit: begin
                disp_d = '0;
                ovf_d  = 1'b0;
                for (int i = 0; i < DISP_N; i++) disp_d[4*i +: 4] = bcd_q[4*i +: 4];
                for (int i = DIGITS; i < NIB; i++) begin
                    if (bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan prescaler and digit index
    always_comb begin
        ps_d  = ps_q + 1'b1;
        idx_d = idx_q;
        if (ps_q == PS_W'(SCAN_DIV - 1)) begin
            ps_d  = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Output decode for the current index; blanking never hides an overflow dash
    always_comb begin
        cur_dig    = 4'd0;
        dp_raw     = 1'b0;
        dig_raw    = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig    = disp_q[4*i +: 4];
                dp_raw     = dp_in[i];
                dig_raw[i] = 1'b1;
            end
            if (IDX_W'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (ovf_q) begin
            seg_raw = 7'h40;
        end else if (blank_lz && idx_q != '0 && upper_zero) begin
            seg_raw = 7'h00;
        end else begin
            seg_raw = enc7(cur_dig);
        end
        seg_d = SEG_ACT_LOW ? ~seg_raw : seg_raw;
        dp_d  = SEG_ACT_LOW ? ~dp_raw : dp_raw;
        dig_d = DIG_ACT_LOW ? ~dig_raw : dig_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ps_q    <= '0;
            idx_q   <= '0;
            seg_q   <= {7{SEG_ACT_LOW}};
            dp_q    <= SEG_ACT_LOW;
            dig_q   <= {DIGITS{DIG_ACT_LOW}};
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.ready = (state_q == StIdle);
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign dig_en    = dig_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_d7s_scan_bcd.sv
// Bench for d7s_scan_bcd: arithmetic display model checked every cycle plus
// literal expectations for each scenario, and a second instance for polarity.
module tb_d7s_scan_bcd;
    localparam int unsigned DIGITS   = 3;
    localparam int unsigned BIN_W    = 10;
    localparam int unsigned SCAN_DIV = 4;
    localparam int          LIMIT    = 1000;

    logic clk = 1'b0;
    logic rst_n;
    logic blank_lz;
    logic [DIGITS-1:0] dp_in;
    logic [6:0] seg;
    logic dp;
    logic [DIGITS-1:0] dig_en;
    logic ovf;

    logic [DIGITS-1:0] dp2_in;
    logic [6:0] seg2;
    logic dp2;
    logic [DIGITS-1:0] dig2;
    logic ovf2;

    int checks = 0;
    int failures = 0;

    d7s_scan_bcd_if #(.BIN_W(BIN_W)) bus ();
    d7s_scan_bcd_if #(.BIN_W(BIN_W)) bus2 ();

    d7s_scan_bcd #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV),
        .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .blank_lz(blank_lz), .dp_in(dp_in),
        .seg(seg), .dp(dp), .dig_en(dig_en), .ovf(ovf)
    );

    d7s_scan_bcd #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV),
        .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .blank_lz(1'b0), .dp_in(dp2_in),
        .seg(seg2), .dp(dp2), .dig_en(dig2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] exp_seg(input int val, input bit ov, input int i,
                                           input bit blz);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (ov) return 7'h40;
        if (blz && i > 0 && val < p) return 7'h00;
        return seg_tab[(val / p) % 10];
    endfunction

    // Model: committed value as an integer, display slot derived from elapsed cycles
    int                m_val, m_pend, m_cyc, m_left;
    bit                m_ovf, m_busy, m_dp;
    logic [6:0]        m_seg;
    logic [DIGITS-1:0] m_dig;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val  <= 0;
            m_pend <= 0;
            m_cyc  <= 0;
            m_left <= 0;
            m_ovf  <= 1'b0;
            m_busy <= 1'b0;
            m_dp   <= 1'b0;
            m_seg  <= 7'h00;
            m_dig  <= '0;
        end else begin
            m_seg <= exp_seg(m_val, m_ovf, (m_cyc / SCAN_DIV) % DIGITS, blank_lz);
            m_dp  <= dp_in[(m_cyc / SCAN_DIV) % DIGITS];
            m_dig <= DIGITS'(1 << ((m_cyc / SCAN_DIV) % DIGITS));
            m_cyc <= m_cyc + 1;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_val  <= m_pend;
                    m_ovf  <= (m_pend >= LIMIT);
                    m_busy <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (bus.load) begin
                m_busy <= 1'b1;
                m_left <= BIN_W + 1;
                m_pend <= int'(bus.bin_in);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        checks++;
        if (seg !== m_seg || dp !== m_dp || dig_en !== m_dig || bus.ready !== !m_busy ||
            ovf !== m_ovf) begin
            failures++;
            $display("FAIL model t=%0t: got seg=%h dp=%b dig=%b rdy=%b ovf=%b want seg=%h dp=%b dig=%b rdy=%b ovf=%b",
                     $time, seg, dp, dig_en, bus.ready, ovf, m_seg, m_dp, m_dig, !m_busy, m_ovf);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_digit(input string name, input logic [DIGITS-1:0] want_dig,
                               input logic [6:0] want_seg);
        int n = 0;
        tick();
        while (dig_en !== want_dig && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_dig"}, 32'(dig_en), 32'(want_dig));
        chk({name, "_seg"}, 32'(seg), 32'(want_seg));
    endtask

    // Called just after a negedge; returns once the new value is on the pins
    task automatic load_val(input int v, input string name);
        int lo = 0;
        bus.bin_in = BIN_W'(v);
        bus.load   = 1'b1;
        tick();
        bus.load = 1'b0;
        while (bus.ready === 1'b0 && lo < 40) begin
            lo++;
            tick();
        end
        chk({name, "_ready_low"}, 32'(lo), 32'd11);
        tick();
    endtask

    initial begin
        int n101;
        logic [DIGITS-1:0] scan_exp [4];
        scan_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst_n       = 1'b1;
        blank_lz    = 1'b0;
        dp_in       = '0;
        dp2_in      = 3'b010;
        bus.bin_in  = '0;
        bus.load    = 1'b0;
        bus2.bin_in = '0;
        bus2.load   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dig", 32'(dig_en), 32'h0);
        chk("rst_ready", 32'(bus.ready), 32'h1);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst2_seg", 32'(seg2), 32'h7F);
        chk("rst2_dp", 32'(dp2), 32'h1);
        chk("rst2_dig", 32'(dig2), 32'h7);

        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("scan_dig", 32'(dig_en), 32'(scan_exp[k / 4]));
            chk("scan_seg", 32'(seg), 32'h3F);
        end

        load_val(789, "l789");
        check_digit("l789_d0", 3'b001, 7'h6F);
        check_digit("l789_d1", 3'b010, 7'h7F);
        check_digit("l789_d2", 3'b100, 7'h07);
        chk("l789_ovf", 32'(ovf), 32'h0);

        dp_in = 3'b101;
        load_val(1000, "l1000");
        chk("l1000_ovf", 32'(ovf), 32'h1);
        check_digit("l1000_d0", 3'b001, 7'h40);
        check_digit("l1000_d1", 3'b010, 7'h40);
        check_digit("l1000_d2", 3'b100, 7'h40);
        load_val(5, "l5");
        chk("l5_ovf", 32'(ovf), 32'h0);
        check_digit("l5_d0", 3'b001, 7'h6D);
        check_digit("l5_d1", 3'b010, 7'h3F);
        check_digit("l5_d2", 3'b100, 7'h3F);

        dp_in    = 3'b000;
        blank_lz = 1'b1;
        load_val(5, "lz5");
        check_digit("lz5_d0", 3'b001, 7'h6D);
        check_digit("lz5_d1", 3'b010, 7'h00);
        check_digit("lz5_d2", 3'b100, 7'h00);
        load_val(105, "lz105");
        check_digit("lz105_d0", 3'b001, 7'h6D);
        check_digit("lz105_d1", 3'b010, 7'h3F);
        check_digit("lz105_d2", 3'b100, 7'h06);

        // Held load with a moving bin_in: only the accepted value may appear
        bus.bin_in = 10'd321;
        bus.load   = 1'b1;
        tick();
        for (int k = 0; k < 11; k++) begin
            bus.bin_in = BIN_W'(400 + k);
            tick();
        end
        bus.load   = 1'b0;
        bus.bin_in = '0;
        tick();
        check_digit("hold_d0", 3'b001, 7'h06);
        check_digit("hold_d1", 3'b010, 7'h5B);
        check_digit("hold_d2", 3'b100, 7'h4F);

        bus.bin_in = 10'd555;
        bus.load   = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.ready), 32'h1);
        chk("midrst_seg", 32'(seg), 32'h00);
        chk("midrst_dig", 32'(dig_en), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        check_digit("midrst_d0", 3'b001, 7'h3F);
        check_digit("midrst_d1", 3'b010, 7'h00);

        bus2.bin_in = 10'd888;
        bus2.load   = 1'b1;
        tick();
        bus2.load = 1'b0;
        repeat (14) tick();
        n101 = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("pol_seg", 32'(seg2), 32'h00);
            chk("pol_dp", 32'(dp2), (dig2 == 3'b101) ? 32'h0 : 32'h1);
            if (dig2 == 3'b101) n101++;
        end
        chk("pol_seen_d1", 32'(n101), 32'd4);
        chk("pol_ovf", 32'(ovf2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
